// File: rtl/song_pkg.sv
// Shared definitions for the song memory entry format, used by the song writer and song reader.
// Entry layout (16 bits):
//   note : {1'b0, note[5:0], dur[5:0], 3'b000}
//   wait : {1'b1, count[5:0], 9'b0}
//   term : 16'h8000
// Memory layout: one slot per song, slot base = {song, {(ADDR_W-2){1'b0}}}.
package song_pkg;

    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned SONG_W    = 2;
    localparam int unsigned IDX_W     = ADDR_W - SONG_W;
    localparam int unsigned SLOT_LEN  = 128;
    localparam int unsigned WAIT_MAX  = 63;
    localparam int unsigned NOTE_W    = 6;
    localparam int unsigned DUR_W     = 6;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned WORD_W    = 16;

    // Entry field positions
    localparam int unsigned WAIT_BIT  = 15;
    localparam int unsigned FIELD_LSB = 9;
    localparam int unsigned DUR_LSB   = 3;

    localparam logic [WORD_W-1:0] TERM_WORD = 16'h8000;

    // Slot index reserved for the terminator
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOT_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_REC,
        ST_FLUSH,
        ST_TERM,
        ST_DONE
    } wr_state_e;

    typedef enum logic [1:0] {
        ENT_NOTE,
        ENT_WAIT,
        ENT_TERM
    } entry_kind_e;

    // Source of the entry written in a given cycle
    typedef enum logic [2:0] {
        WS_NONE,
        WS_HOLD,
        WS_FORCE,
        WS_NOTE,
        WS_WAIT,
        WS_TERM
    } wr_sel_e;

    typedef struct packed {
        entry_kind_e       kind;
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
        logic [CNT_W-1:0]  count;
    } entry_req_t;

    function automatic logic [ADDR_W-1:0] slot_base(input logic [SONG_W-1:0] song);
        return {song, {IDX_W{1'b0}}};
    endfunction

endpackage

// File: rtl/song_entry_enc.sv
// Combinational song entry encoder: packs a {kind, note, dur, count} request into a 16-bit word.
// Ports:
//   req_i  - entry request (kind selects which fields are used)
//   word_c - encoded 16-bit song memory word (combinational)
module song_entry_enc
    import song_pkg::*;
(
    input  entry_req_t        req_i,
    output logic [WORD_W-1:0] word_c
);

    always_comb begin
        word_c = '0;
        case (req_i.kind)
            ENT_NOTE: begin
                word_c[WAIT_BIT]                = 1'b0;
                word_c[FIELD_LSB +: NOTE_W]     = req_i.note;
                word_c[DUR_LSB +: DUR_W]        = req_i.dur;
            end
            ENT_WAIT: begin
                word_c[WAIT_BIT]                = 1'b1;
                word_c[FIELD_LSB +: CNT_W]      = req_i.count;
            end
            default: begin
                word_c = TERM_WORD;
            end
        endcase
    end

endmodule

// File: rtl/song_writer.sv
// Song writer: records a live note stream into one 128-entry slot of song memory.
// Beats between notes become wait entries (split at 63), and the take is closed
// with a terminator word at the current pointer.
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   record               - level; rise in IDLE starts a take, fall while recording stops it
//   song[1:0]            - slot select, sampled on record rise
//   beat                 - one-cycle beat strobe
//   note_valid/note_ready- note handshake (ready registered)
//   note[5:0], duration  - note code and duration in beats
//   wr_en/wr_addr/wr_data- registered song RAM write port
//   busy                 - high while arming, recording, flushing or terminating
//   rec_done             - high in DONE
//   overflow             - sticky, take truncated because the slot filled
// Build option: define SONG_WRITER_LEAD_WAIT_EN to record silence before the first
// note as leading wait entries; otherwise the gap counter is held at 0 until then.
module song_writer
    import song_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              record,
    input  logic [SONG_W-1:0] song,
    input  logic              beat,
    input  logic              note_valid,
    output logic              note_ready,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              rec_done,
    output logic              overflow
);

    wr_state_e         state_q;
    logic              record_q;
    logic [SONG_W-1:0] song_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  gap_q;
    logic              hold_valid_q;
    logic [NOTE_W-1:0] hold_note_q;
    logic [DUR_W-1:0]  hold_dur_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WORD_W-1:0] wr_data_q;
    logic              note_ready_q;
    logic              busy_q;
    logic              rec_done_q;
    logic              overflow_q;

    logic              accept_c;
    logic              count_en_c;
    logic              force_c;
    logic              next_hold_c;
    logic [CNT_W-1:0]  gap_inc_c;
    wr_sel_e           wr_sel_c;
    entry_req_t        enc_req_c;
    logic [WORD_W-1:0] enc_word_c;

    assign accept_c = note_valid & note_ready_q;

`ifdef SONG_WRITER_LEAD_WAIT_EN
    assign count_en_c = 1'b1;
`else
    // Gap counting starts only once the first note of the take is accepted
    logic started_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q <= 1'b0;
        end else if (state_q == ST_ARM) begin
            started_q <= 1'b0;
        end else if (state_q == ST_REC && accept_c && ptr_q != LAST_IDX) begin
            started_q <= 1'b1;
        end
    end

    assign count_en_c = started_q;
`endif

    // A beat that would take the gap to WAIT_MAX forces a full-length wait entry
    assign force_c   = count_en_c & beat & (gap_q == CNT_W'(WAIT_MAX - 1));
    assign gap_inc_c = gap_q + CNT_W'(beat & count_en_c);

    // Write source priority: held note > forced wait > new note/wait
    always_comb begin
        wr_sel_c = WS_NONE;
        case (state_q)
            ST_REC: begin
                if (ptr_q != LAST_IDX) begin
                    if (hold_valid_q) begin
                        wr_sel_c = WS_HOLD;
                    end else if (force_c) begin
                        wr_sel_c = WS_FORCE;
                    end else if (accept_c) begin
                        wr_sel_c = (gap_q == '0) ? WS_NOTE : WS_WAIT;
                    end
                end
            end
            ST_FLUSH: begin
                if (ptr_q != LAST_IDX) begin
                    if (hold_valid_q) begin
                        wr_sel_c = WS_HOLD;
                    end else if (gap_q != '0) begin
                        wr_sel_c = WS_WAIT;
                    end
                end
            end
            ST_TERM: begin
                wr_sel_c = WS_TERM;
            end
            default: begin
                wr_sel_c = WS_NONE;
            end
        endcase
    end

    // Note left waiting behind a wait entry written this cycle
    assign next_hold_c = (wr_sel_c == WS_WAIT && state_q == ST_REC)
                       || (wr_sel_c == WS_FORCE && accept_c);

    // Entry request for the selected write source
    always_comb begin
        enc_req_c      = '0;
        enc_req_c.kind = ENT_TERM;
        case (wr_sel_c)
            WS_HOLD: begin
                enc_req_c.kind = ENT_NOTE;
                enc_req_c.note = hold_note_q;
                enc_req_c.dur  = hold_dur_q;
            end
            WS_FORCE: begin
                enc_req_c.kind  = ENT_WAIT;
                enc_req_c.count = CNT_W'(WAIT_MAX);
            end
            WS_NOTE: begin
                enc_req_c.kind = ENT_NOTE;
                enc_req_c.note = note;
                enc_req_c.dur  = duration;
            end
            WS_WAIT: begin
                enc_req_c.kind  = ENT_WAIT;
                enc_req_c.count = gap_q;
            end
            default: begin
                enc_req_c.kind = ENT_TERM;
            end
        endcase
    end

    song_entry_enc u_enc (
        .req_i  (enc_req_c),
        .word_c (enc_word_c)
    );

    // Take control FSM and registered write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            record_q     <= 1'b0;
            song_q       <= '0;
            ptr_q        <= '0;
            gap_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_note_q  <= '0;
            hold_dur_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            note_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            rec_done_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            record_q <= record;
            wr_en_q  <= (wr_sel_c != WS_NONE);
            if (wr_sel_c != WS_NONE) begin
                wr_addr_q <= slot_base(song_q) | ADDR_W'(ptr_q);
                wr_data_q <= enc_word_c;
            end

            case (state_q)
                ST_IDLE: begin
                    note_ready_q <= 1'b0;
                    if (record && !record_q) begin
                        song_q     <= song;
                        ptr_q      <= '0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ARM;
                    end
                end

                ST_ARM: begin
                    gap_q        <= '0;
                    hold_valid_q <= 1'b0;
                    note_ready_q <= 1'b1;
                    state_q      <= ST_REC;
                end

                ST_REC: begin
                    if (ptr_q == LAST_IDX) begin
                        // Slot full: any held or offered note is dropped
                        overflow_q   <= 1'b1;
                        hold_valid_q <= 1'b0;
                        note_ready_q <= 1'b0;
                        state_q      <= ST_TERM;
                    end else begin
                        case (wr_sel_c)
                            WS_HOLD: begin
                                ptr_q        <= ptr_q + IDX_W'(1);
                                hold_valid_q <= 1'b0;
                                gap_q        <= gap_inc_c;
                            end
                            WS_FORCE: begin
                                ptr_q <= ptr_q + IDX_W'(1);
                                gap_q <= '0;
                                if (accept_c) begin
                                    hold_valid_q <= 1'b1;
                                    hold_note_q  <= note;
                                    hold_dur_q   <= duration;
                                end
                            end
                            WS_NOTE: begin
                                ptr_q <= ptr_q + IDX_W'(1);
                                gap_q <= CNT_W'(beat);
                            end
                            WS_WAIT: begin
                                // Beat in the same cycle belongs to the new gap
                                ptr_q        <= ptr_q + IDX_W'(1);
                                gap_q        <= CNT_W'(beat);
                                hold_valid_q <= 1'b1;
                                hold_note_q  <= note;
                                hold_dur_q   <= duration;
                            end
                            default: begin
                                gap_q <= gap_inc_c;
                            end
                        endcase
                        note_ready_q <= record & ~next_hold_c;
                        if (!record) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end

                ST_FLUSH: begin
                    note_ready_q <= 1'b0;
                    if (ptr_q == LAST_IDX) begin
                        overflow_q   <= overflow_q | hold_valid_q;
                        hold_valid_q <= 1'b0;
                        state_q      <= ST_TERM;
                    end else begin
                        case (wr_sel_c)
                            WS_HOLD: begin
                                ptr_q        <= ptr_q + IDX_W'(1);
                                hold_valid_q <= 1'b0;
                            end
                            WS_WAIT: begin
                                ptr_q   <= ptr_q + IDX_W'(1);
                                gap_q   <= '0;
                                state_q <= ST_TERM;
                            end
                            default: begin
                                state_q <= ST_TERM;
                            end
                        endcase
                    end
                end

                ST_TERM: begin
                    busy_q     <= 1'b0;
                    rec_done_q <= 1'b1;
                    state_q    <= ST_DONE;
                end

                ST_DONE: begin
                    if (!record) begin
                        rec_done_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign note_ready = note_ready_q;
    assign busy       = busy_q;
    assign rec_done   = rec_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_song_writer.sv
// Bench for song_writer: directed and randomized takes compared against an
// entry-list model built from the recording rules (gap counting in beats).
module tb_song_writer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       record;
    logic [1:0] song;
    logic       beat;
    logic       note_valid;
    logic       note_ready;
    logic [5:0] note;
    logic [5:0] duration;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [15:0] wr_data;
    logic       busy;
    logic       rec_done;
    logic       overflow;

    always #5 clk = ~clk;

    song_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .record     (record),
        .song       (song),
        .beat       (beat),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note       (note),
        .duration   (duration),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .rec_done   (rec_done),
        .overflow   (overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Captured RAM writes
    logic [8:0]  cap_addr[$];
    logic [15:0] cap_data[$];

    always @(negedge clk) begin
        if (wr_en) begin
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
        end
    end

    // Per-cycle stimulus for the current take
    bit         ev_nv[$];
    bit         ev_bt[$];
    logic [5:0] ev_nt[$];
    logic [5:0] ev_du[$];

    task automatic add_ev(input bit nv, input bit bt, input logic [5:0] nt, input logic [5:0] du);
        ev_nv.push_back(nv);
        ev_bt.push_back(bt);
        ev_nt.push_back(nt);
        ev_du.push_back(du);
    endtask

    // Reference model: ordered list of expected entries plus current silence length
    logic [15:0] exp_q[$];
    int          gap;
    bit          started;
    int          ready_low;

`ifdef SONG_WRITER_LEAD_WAIT_EN
    localparam bit LEAD_EN = 1'b1;
`else
    localparam bit LEAD_EN = 1'b0;
`endif

    function automatic logic [15:0] wait_word(input int c);
        return 16'(32'h8000 + c * 512);
    endfunction

    function automatic logic [15:0] note_word(input logic [5:0] nt, input logic [5:0] du);
        return 16'(int'(nt) * 512 + int'(du) * 8);
    endfunction

    task automatic model_cycle(input bit a, input bit b, input logic [5:0] nt, input logic [5:0] du);
        bit counting;
        if (exp_q.size() >= 127) return;
        counting = LEAD_EN || started;
        if (a) begin
            if (counting && b && gap == 62) begin
                // the beat completes a full 63-beat silence ahead of the note
                exp_q.push_back(wait_word(63));
                exp_q.push_back(note_word(nt, du));
                gap = 0;
            end else begin
                if (gap > 0) exp_q.push_back(wait_word(gap));
                exp_q.push_back(note_word(nt, du));
                gap = b ? 1 : 0;
            end
            started = 1'b1;
        end else if (counting && b) begin
            gap++;
            if (gap == 63) begin
                exp_q.push_back(wait_word(63));
                gap = 0;
            end
        end
    endtask

    task automatic drive_cycle(input bit nv, input bit bt, input logic [5:0] nt, input logic [5:0] du);
        @(posedge clk);
        #1;
        note_valid = nv;
        beat       = bt;
        note       = nt;
        duration   = du;
        @(negedge clk);
        if (!note_ready) ready_low++;
        model_cycle(note_valid & note_ready, beat, note, duration);
    endtask

    task automatic start_take(input logic [1:0] s, input string tag);
        int n;
        exp_q.delete();
        cap_addr.delete();
        cap_data.delete();
        gap       = 0;
        started   = 1'b0;
        ready_low = 0;
        @(posedge clk);
        #1;
        song   = s;
        record = 1'b1;
        n = 0;
        @(negedge clk);
        while (!note_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, 32'(note_ready), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic run_take(input logic [1:0] s, input string tag);
        int n;
        bit ovf;
        int base;
        start_take(s, tag);
        for (int i = 0; i < ev_nv.size(); i++) begin
            drive_cycle(ev_nv[i], ev_bt[i], ev_nt[i], ev_du[i]);
        end
        drive_cycle(1'b0, 1'b0, 6'd0, 6'd0);
        drive_cycle(1'b0, 1'b0, 6'd0, 6'd0);
        ev_nv.delete();
        ev_bt.delete();
        ev_nt.delete();
        ev_du.delete();

        @(posedge clk);
        #1;
        record     = 1'b0;
        note_valid = 1'b0;
        beat       = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rec_done && n < 12) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, 32'(rec_done), 32'd1);

        ovf = (exp_q.size() >= 127);
        if (ovf) begin
            while (exp_q.size() > 127) void'(exp_q.pop_back());
        end else if (gap > 0) begin
            exp_q.push_back(wait_word(gap));
        end
        exp_q.push_back(16'h8000);
        check_eq({tag, "_ovf"}, 32'(overflow), 32'(ovf));

        @(negedge clk);
        @(negedge clk);
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_idle_done"}, 32'(rec_done), 32'd0);

        base = int'(s) * 128;
        check_eq({tag, "_nwr"}, 32'(cap_data.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_data.size()) begin
                check_eq($sformatf("%s_addr%0d", tag, i), 32'(cap_addr[i]), 32'(base + i));
                check_eq($sformatf("%s_data%0d", tag, i), 32'(cap_data[i]), 32'(exp_q[i]));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int nev;
        int pn;
        int pb;
        reset_n    = 1'b0;
        record     = 1'b0;
        song       = 2'd0;
        beat       = 1'b0;
        note_valid = 1'b0;
        note       = 6'd0;
        duration   = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_ready", 32'(note_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(rec_done), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_data", 32'(wr_data), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single note then stop
        add_ev(1'b1, 1'b0, 6'd12, 6'd4);
        run_take(2'd1, "t1");
        check_eq("t1_addr_abs", 32'(cap_addr.size() > 0 ? cap_addr[0] : 9'd0), 32'd128);
        check_eq("t1_word", 32'(cap_data.size() > 0 ? cap_data[0] : 16'd0), 32'h1820);

        // Note, three beats, note: wait entry and one-cycle ready drop
        add_ev(1'b1, 1'b0, 6'd5, 6'd2);
        repeat (3) add_ev(1'b0, 1'b1, 6'd0, 6'd0);
        add_ev(1'b1, 1'b0, 6'd9, 6'd1);
        run_take(2'd2, "t2");
        check_eq("t2_ready_low", 32'(ready_low), 32'd1);
        check_eq("t2_wait", 32'(cap_data.size() > 1 ? cap_data[1] : 16'd0), 32'h8600);

        // 70 silent beats between notes: split into 63 + 7
        add_ev(1'b1, 1'b0, 6'd7, 6'd3);
        repeat (70) add_ev(1'b0, 1'b1, 6'd0, 6'd0);
        add_ev(1'b1, 1'b0, 6'd8, 6'd3);
        run_take(2'd0, "t3");
        check_eq("t3_w63", 32'(cap_data.size() > 1 ? cap_data[1] : 16'd0), 32'hFE00);
        check_eq("t3_w7", 32'(cap_data.size() > 2 ? cap_data[2] : 16'd0), 32'h8E00);

        // 63rd beat coincides with a note
        add_ev(1'b1, 1'b0, 6'd3, 6'd3);
        repeat (62) add_ev(1'b0, 1'b1, 6'd0, 6'd0);
        add_ev(1'b1, 1'b1, 6'd4, 6'd5);
        run_take(2'd1, "t7");

        // Slot overflow with back-to-back notes
        for (int i = 0; i < 130; i++) add_ev(1'b1, 1'b0, 6'($urandom_range(1, 63)), 6'($urandom_range(0, 63)));
        run_take(2'd3, "t4");
        check_eq("t4_ovf_abs", 32'(overflow), 32'd1);
        check_eq("t4_term_addr", 32'(cap_addr.size() > 0 ? cap_addr[cap_addr.size() - 1] : 9'd0), 32'd511);

        // Beats before the first note
        add_ev(1'b0, 1'b1, 6'd0, 6'd0);
        add_ev(1'b0, 1'b1, 6'd0, 6'd0);
        add_ev(1'b1, 1'b0, 6'd20, 6'd6);
        run_take(2'd0, "t6");

        // Reset in the middle of a take
        start_take(2'd2, "t5a");
        drive_cycle(1'b1, 1'b0, 6'd11, 6'd2);
        drive_cycle(1'b1, 1'b0, 6'd12, 6'd2);
        @(posedge clk);
        #2;
        check_eq("t5_pre_wr", 32'(wr_en), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("t5_wr_en", 32'(wr_en), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_ready", 32'(note_ready), 32'd0);
        record     = 1'b0;
        note_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        add_ev(1'b1, 1'b0, 6'd33, 6'd9);
        add_ev(1'b0, 1'b1, 6'd0, 6'd0);
        add_ev(1'b1, 1'b0, 6'd34, 6'd9);
        run_take(2'd2, "t5");

        // Randomized takes
        for (int t = 0; t < 8; t++) begin
            nev = int'($urandom_range(40, 260));
            pn  = (t == 7) ? 80 : int'($urandom_range(1, 40));
            pb  = int'($urandom_range(10, 90));
            for (int i = 0; i < nev; i++) begin
                add_ev(($urandom_range(0, 99) < pn), ($urandom_range(0, 99) < pb),
                       6'($urandom_range(1, 63)), 6'($urandom_range(0, 63)));
            end
            run_take(2'($urandom_range(0, 3)), $sformatf("r%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
